// File: rtl/aud_mem_arbiter.sv
// Arbitrates one single-port audio word memory between recorder (write), echo processor
// and player (reads). Define ARB_RR_EN for round-robin arbitration; default is fixed priority.
module aud_mem_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 256,
    parameter int RD_LAT    = 1,
    parameter int LAST_ADDR = 122
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rec_req_i,
    input  logic [ADDR_W-1:0] rec_addr_i,
    input  logic [DATA_W-1:0] rec_wdata_i,
    output logic              rec_ack_o,
    input  logic              prc_req_i,
    input  logic [ADDR_W-1:0] prc_addr_i,
    output logic              prc_ack_o,
    input  logic              ply_req_i,
    input  logic [ADDR_W-1:0] ply_addr_i,
    output logic              ply_ack_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              addr_err_o,
    output logic              busy_o,
    output logic [1:0]        gnt_id_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_wren_o,
    input  logic [DATA_W-1:0] mem_q_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [1:0]        ID_NONE  = 2'd0;
    localparam logic [1:0]        ID_REC   = 2'd1;
    localparam logic [1:0]        ID_PRC   = 2'd2;
    localparam logic [1:0]        ID_PLY   = 2'd3;
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(LAST_ADDR);
    localparam logic [1:0]        CNT_LOAD = 2'(RD_LAT - 1);

    state_e            state_q;
    logic [1:0]        gnt_id_q;
    logic [1:0]        cnt_q;
    logic              busy_q;
    logic              rec_ack_q, prc_ack_q, ply_ack_q, addr_err_q;
    logic              mem_wren_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rd_data_q;

    logic [1:0]        win_id_d;
    logic [ADDR_W-1:0] win_addr_d;

`ifdef ARB_RR_EN
    logic [1:0] rr_last_q;  // id of the most recent grantee; the search starts just after it

    always_comb begin
        logic [1:0] cand;
        logic       hit;
        win_id_d = ID_NONE;
        cand     = rr_last_q;
        for (int i = 0; i < 3; i++) begin
            cand = (cand == ID_PLY) ? ID_REC : cand + 2'd1;
            unique case (cand)
                ID_REC:  hit = rec_req_i;
                ID_PRC:  hit = prc_req_i;
                ID_PLY:  hit = ply_req_i;
                default: hit = 1'b0;
            endcase
            if (win_id_d == ID_NONE && hit) win_id_d = cand;
        end
    end
`else
    always_comb begin
        win_id_d = ID_NONE;
        if (rec_req_i)      win_id_d = ID_REC;
        else if (prc_req_i) win_id_d = ID_PRC;
        else if (ply_req_i) win_id_d = ID_PLY;
    end
`endif

    always_comb begin
        unique case (win_id_d)
            ID_REC:  win_addr_d = rec_addr_i;
            ID_PRC:  win_addr_d = prc_addr_i;
            ID_PLY:  win_addr_d = ply_addr_i;
            default: win_addr_d = '0;
        endcase
    end

    // NOTE: every register, including the wide data words, is cleared by the synchronous
    // reset because all outputs must read 0 the cycle after reset, even mid-access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            gnt_id_q    <= ID_NONE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            rec_ack_q   <= 1'b0;
            prc_ack_q   <= 1'b0;
            ply_ack_q   <= 1'b0;
            addr_err_q  <= 1'b0;
            mem_wren_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
`ifdef ARB_RR_EN
            rr_last_q   <= ID_REC;
`endif
        end else begin
            // Acks, error and write enable are single-cycle pulses unless re-armed below.
            rec_ack_q  <= 1'b0;
            prc_ack_q  <= 1'b0;
            ply_ack_q  <= 1'b0;
            addr_err_q <= 1'b0;
            mem_wren_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (win_id_d != ID_NONE) begin
                        gnt_id_q <= win_id_d;
                        busy_q   <= 1'b1;
`ifdef ARB_RR_EN
                        rr_last_q <= win_id_d;
`endif
                        if (win_addr_d > LAST_A) begin
                            state_q    <= RESP;
                            addr_err_q <= 1'b1;
                            rec_ack_q  <= (win_id_d == ID_REC);
                            prc_ack_q  <= (win_id_d == ID_PRC);
                            ply_ack_q  <= (win_id_d == ID_PLY);
                        end else begin
                            state_q    <= ISSUE;
                            mem_addr_q <= win_addr_d;
                            if (win_id_d == ID_REC) begin
                                mem_wren_q  <= 1'b1;
                                mem_wdata_q <= rec_wdata_i;
                                rec_ack_q   <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (gnt_id_q == ID_REC) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        gnt_id_q <= ID_NONE;
                    end else begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        rd_data_q <= mem_q_i;
                        prc_ack_q <= (gnt_id_q == ID_PRC);
                        ply_ack_q <= (gnt_id_q == ID_PLY);
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    gnt_id_q <= ID_NONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rec_ack_o   = rec_ack_q;
    assign prc_ack_o   = prc_ack_q;
    assign ply_ack_o   = ply_ack_q;
    assign rd_data_o   = rd_data_q;
    assign addr_err_o  = addr_err_q;
    assign busy_o      = busy_q;
    assign gnt_id_o    = gnt_id_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wren_o  = mem_wren_q;

endmodule

// File: tb/tb_aud_mem_arbiter.sv
// Bench for aud_mem_arbiter: behavioural memory, random traffic against a transaction-level
// model, and directed scenarios for latency, contention, range errors and reset.
module tb_aud_mem_arbiter;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 256;
    localparam int RD_LAT    = 3;
    localparam int LAST_ADDR = 122;
    localparam int NCYC      = 2500;

    logic              clk = 1'b0;
    logic              rst;
    logic              rec_req, prc_req, ply_req;
    logic [ADDR_W-1:0] rec_addr, prc_addr, ply_addr;
    logic [DATA_W-1:0] rec_wdata;
    logic              rec_ack, prc_ack, ply_ack, addr_err, busy, mem_wren;
    logic [1:0]        gnt_id;
    logic [DATA_W-1:0] rd_data, mem_wdata, mem_q;
    logic [ADDR_W-1:0] mem_addr;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aud_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .LAST_ADDR(LAST_ADDR)) dut (
        .clk_i(clk), .rst_i(rst),
        .rec_req_i(rec_req), .rec_addr_i(rec_addr), .rec_wdata_i(rec_wdata), .rec_ack_o(rec_ack),
        .prc_req_i(prc_req), .prc_addr_i(prc_addr), .prc_ack_o(prc_ack),
        .ply_req_i(ply_req), .ply_addr_i(ply_addr), .ply_ack_o(ply_ack),
        .rd_data_o(rd_data), .addr_err_o(addr_err), .busy_o(busy), .gnt_id_o(gnt_id),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wren_o(mem_wren), .mem_q_i(mem_q)
    );

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        return {8{24'hC0DE00, 1'b0, a}};
    endfunction

    // Memory macro model: unwritten words read back a per-address pattern.
    logic [DATA_W-1:0] mem [0:127];
    bit                mem_wr [0:127];
    bit [ADDR_W-1:0]   rd_pipe [0:RD_LAT-1];

    always @(posedge clk) begin
        if (mem_wren) begin
            mem[mem_addr]    <= mem_wdata;
            mem_wr[mem_addr] <= 1'b1;
        end
        rd_pipe[0] <= mem_addr;
        for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign mem_q = mem_wr[rd_pipe[RD_LAT-1]] ? mem[rd_pipe[RD_LAT-1]] : pattern(rd_pipe[RD_LAT-1]);

    // Reference contents, maintained from what the bench expects to have been written.
    logic [DATA_W-1:0] ref_mem [0:127];
    bit                ref_wr [0:127];

    function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] a);
        return ref_wr[a] ? ref_mem[a] : pattern(a);
    endfunction

    task automatic ref_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ref_mem[a] = d;
        ref_wr[a]  = 1'b1;
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        int sel;
        sel = $urandom_range(7, 0);
        if (sel == 0) return ADDR_W'($urandom_range(127, 123));
        if (sel == 1) return ADDR_W'(LAST_ADDR);
        return ADDR_W'($urandom_range(LAST_ADDR, 0));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rec_req = 1'b0; prc_req = 1'b0; ply_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({busy, gnt_id, rec_ack, prc_ack, ply_ack, addr_err, mem_wren} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_ctrl got=%b exp=%b", {busy, gnt_id, rec_ack, prc_ack, ply_ack, addr_err, mem_wren}, 8'h00);
        end
        n_vec++;
        if (mem_addr !== '0 || rd_data !== '0 || mem_wdata !== '0) begin
            n_bad++;
            $display("FAIL reset_data got addr=%h rd=%h wd=%h exp all zero", mem_addr, rd_data, mem_wdata);
        end
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (busy !== 1'b0 || gnt_id !== 2'd0) begin
                n_bad++;
                $display("FAIL reset_idle got busy=%b gnt=%0d exp busy=0 gnt=0", busy, gnt_id);
            end
        end
    endtask

    task automatic test_random();
        bit                rq [1:3];
        logic [ADDR_W-1:0] ra [1:3];
        logic [DATA_W-1:0] rw [1:3];
        int                t0, busy_end, last_id, k, win, tr_id;
        bit                tr_valid, tr_oor, act;
        logic [ADDR_W-1:0] tr_addr, e_addr;
        logic [DATA_W-1:0] tr_wdata, e_rd;
        logic              e_busy, e_err, e_wren;
        logic [1:0]        e_gnt;
        logic [3:1]        e_ack;
        do_reset();
        for (int r = 1; r <= 3; r++) begin rq[r] = 1'b0; ra[r] = '0; rw[r] = '0; end
        t0 = 0; busy_end = 0; last_id = 1; tr_valid = 1'b0; tr_id = 0; tr_oor = 1'b0;
        tr_addr = '0; tr_wdata = '0; e_addr = '0; e_rd = '0;
        for (int c = 0; c < NCYC; c++) begin
            act    = tr_valid && c > t0 && c < busy_end;
            k      = c - t0;
            e_busy = act;
            e_gnt  = act ? 2'(tr_id) : 2'd0;
            e_ack  = '0; e_err = 1'b0; e_wren = 1'b0;
            if (act) begin
                if (tr_oor) begin
                    e_ack[tr_id] = 1'b1; e_err = 1'b1;
                end else begin
                    e_addr = tr_addr;
                    if (tr_id == 1) begin
                        e_wren = 1'b1; e_ack[1] = 1'b1;
                    end else if (k == RD_LAT + 2) begin
                        e_ack[tr_id] = 1'b1; e_rd = exp_word(tr_addr);
                    end
                end
            end
            n_vec++;
            if ({busy, gnt_id, rec_ack, prc_ack, ply_ack, addr_err, mem_wren} !==
                {e_busy, e_gnt, e_ack[1], e_ack[2], e_ack[3], e_err, e_wren}) begin
                n_bad++;
                $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b (busy,gnt,rec,prc,ply,err,wren)", c,
                         {busy, gnt_id, rec_ack, prc_ack, ply_ack, addr_err, mem_wren},
                         {e_busy, e_gnt, e_ack[1], e_ack[2], e_ack[3], e_err, e_wren});
            end
            n_vec++;
            if (mem_addr !== e_addr) begin
                n_bad++;
                $display("FAIL rnd_addr cyc=%0d got=%0d exp=%0d", c, mem_addr, e_addr);
            end
            n_vec++;
            if (rd_data !== e_rd) begin
                n_bad++;
                $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, rd_data, e_rd);
            end
            if (e_wren) begin
                n_vec++;
                if (mem_wdata !== tr_wdata) begin
                    n_bad++;
                    $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", c, mem_wdata, tr_wdata);
                end
                ref_store(tr_addr, tr_wdata);
            end

            // Requester behaviour for the next edge.
            for (int r = 1; r <= 3; r++) begin
                if (rq[r] && e_ack[r]) begin
                    if (c < NCYC - 100 && $urandom_range(1, 0) == 0) begin
                        ra[r] = rand_addr(); rw[r] = rand_word();
                    end else begin
                        rq[r] = 1'b0;
                    end
                end else if (rq[r] && tr_valid && tr_id == r && c < busy_end) begin
                    if ($urandom_range(3, 0) == 0) begin ra[r] = rand_addr(); rw[r] = rand_word(); end
                end else if (rq[r]) begin
                    if ($urandom_range(15, 0) == 0) rq[r] = 1'b0;
                end else if (c < NCYC - 100 && $urandom_range(2, 0) == 0) begin
                    rq[r] = 1'b1; ra[r] = rand_addr(); rw[r] = rand_word();
                end
            end
            rec_req = rq[1]; rec_addr = ra[1]; rec_wdata = rw[1];
            prc_req = rq[2]; prc_addr = ra[2];
            ply_req = rq[3]; ply_addr = ra[3];

            if (c >= busy_end) begin
                win = 0;
`ifdef ARB_RR_EN
                for (int i = 1; i <= 3; i++) begin
                    int cand;
                    cand = (last_id - 1 + i) % 3 + 1;
                    if (win == 0 && rq[cand]) win = cand;
                end
`else
                for (int r = 1; r <= 3; r++) if (win == 0 && rq[r]) win = r;
`endif
                if (win != 0) begin
                    tr_valid = 1'b1; tr_id = win; tr_addr = ra[win]; tr_wdata = rw[win];
                    tr_oor   = (ra[win] > ADDR_W'(LAST_ADDR));
                    t0       = c;
                    busy_end = c + ((tr_oor || win == 1) ? 2 : RD_LAT + 3);
                    last_id  = win;
                end
            end
            @(negedge clk);
        end
        rec_req = 1'b0; prc_req = 1'b0; ply_req = 1'b0;
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] a5;
        a5 = {32{8'hA5}};
        do_reset();
        rec_req = 1'b1; rec_addr = 7'd5; rec_wdata = a5;
        @(negedge clk);
        n_vec++;
        if (mem_wren !== 1'b1 || rec_ack !== 1'b1 || mem_addr !== 7'd5 || gnt_id !== 2'd1) begin
            n_bad++;
            $display("FAIL wr_cycle1 got wren=%b ack=%b addr=%0d gnt=%0d exp 1 1 5 1", mem_wren, rec_ack, mem_addr, gnt_id);
        end
        n_vec++;
        if (mem_wdata !== a5) begin
            n_bad++;
            $display("FAIL wr_data got=%h exp=%h", mem_wdata, a5);
        end
        rec_req = 1'b0;
        ref_store(7'd5, a5);
        @(negedge clk);
        n_vec++;
        if (mem_wren !== 1'b0 || rec_ack !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_cycle2 got wren=%b ack=%b busy=%b exp 0 0 0", mem_wren, rec_ack, busy);
        end
        prc_req = 1'b1; prc_addr = 7'd5;
        for (int k = 1; k <= RD_LAT + 2; k++) begin
            @(negedge clk);
            n_vec++;
            if (prc_ack !== (k == RD_LAT + 2)) begin
                n_bad++;
                $display("FAIL rd_ack_timing cycle=%0d got=%b exp=%b", k, prc_ack, k == RD_LAT + 2);
            end
        end
        n_vec++;
        if (rd_data !== a5) begin
            n_bad++;
            $display("FAIL rd_back got=%h exp=%h", rd_data, a5);
        end
        prc_req = 1'b0;
        @(negedge clk);
        n_vec++;
        if (prc_ack !== 1'b0 || rd_data !== a5) begin
            n_bad++;
            $display("FAIL rd_after got ack=%b rd=%h exp ack=0 rd=%h", prc_ack, rd_data, a5);
        end
    endtask

    task automatic test_latency();
        prc_req = 1'b1; prc_addr = 7'd0;
        for (int k = 1; k <= RD_LAT + 2; k++) begin
            @(negedge clk);
            if (k <= RD_LAT + 1) begin
                n_vec++;
                if (mem_addr !== 7'd0 || prc_ack !== 1'b0 || gnt_id !== 2'd2 || mem_wren !== 1'b0) begin
                    n_bad++;
                    $display("FAIL lat_hold cycle=%0d got addr=%0d ack=%b gnt=%0d wren=%b exp 0 0 2 0", k, mem_addr, prc_ack, gnt_id, mem_wren);
                end
            end
        end
        n_vec++;
        if (prc_ack !== 1'b1 || rd_data !== exp_word(7'd0)) begin
            n_bad++;
            $display("FAIL lat_ack got ack=%b rd=%h exp ack=1 rd=%h", prc_ack, rd_data, exp_word(7'd0));
        end
        prc_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        ply_req = 1'b1; ply_addr = 7'd123;
        @(negedge clk);
        n_vec++;
        if (ply_ack !== 1'b1 || addr_err !== 1'b1 || gnt_id !== 2'd3 || mem_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL oor_ply got ack=%b err=%b gnt=%0d wren=%b exp 1 1 3 0", ply_ack, addr_err, gnt_id, mem_wren);
        end
        n_vec++;
        if (mem_addr !== 7'd0 || rd_data !== exp_word(7'd0)) begin
            n_bad++;
            $display("FAIL oor_untouched got addr=%0d rd=%h exp addr=0 rd=%h", mem_addr, rd_data, exp_word(7'd0));
        end
        ply_req = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ply_ack !== 1'b0 || addr_err !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL oor_after got ack=%b err=%b busy=%b exp 0 0 0", ply_ack, addr_err, busy);
        end
        rec_req = 1'b1; rec_addr = 7'd127; rec_wdata = rand_word();
        @(negedge clk);
        n_vec++;
        if (rec_ack !== 1'b1 || addr_err !== 1'b1 || mem_wren !== 1'b0 || mem_addr !== 7'd0) begin
            n_bad++;
            $display("FAIL oor_rec got ack=%b err=%b wren=%b addr=%0d exp 1 1 0 0", rec_ack, addr_err, mem_wren, mem_addr);
        end
        rec_req = 1'b0;
        @(negedge clk);
        prc_req = 1'b1; prc_addr = 7'(LAST_ADDR);
        for (int k = 1; k <= RD_LAT + 2; k++) @(negedge clk);
        n_vec++;
        if (prc_ack !== 1'b1 || addr_err !== 1'b0 || rd_data !== exp_word(7'(LAST_ADDR))) begin
            n_bad++;
            $display("FAIL last_addr got ack=%b err=%b rd=%h exp 1 0 %h", prc_ack, addr_err, rd_data, exp_word(7'(LAST_ADDR)));
        end
        prc_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        int         order [$];
        int         exp_order [3];
        logic [1:0] prev;
        int         cyc, n_acks;
`ifdef ARB_RR_EN
        exp_order = '{2, 3, 1};
`else
        exp_order = '{1, 2, 3};
`endif
        do_reset();
        rec_req = 1'b1; rec_addr = 7'd10; rec_wdata = rand_word();
        prc_req = 1'b1; prc_addr = 7'd11;
        ply_req = 1'b1; ply_addr = 7'd12;
        prev = 2'd0; cyc = 0;
        while ((rec_req || prc_req || ply_req) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (gnt_id != 2'd0 && prev == 2'd0) order.push_back(int'(gnt_id));
            prev   = gnt_id;
            n_acks = int'(rec_ack) + int'(prc_ack) + int'(ply_ack);
            n_vec++;
            if (n_acks > 1) begin
                n_bad++;
                $display("FAIL cont_overlap cyc=%0d got %0d acks exp at most 1", cyc, n_acks);
            end
            if (rec_ack) rec_req = 1'b0;
            if (prc_ack) prc_req = 1'b0;
            if (ply_ack) ply_req = 1'b0;
        end
        n_vec++;
        if (rec_req || prc_req || ply_req) begin
            n_bad++;
            $display("FAIL cont_timeout got pending reqs=%b%b%b exp all served", rec_req, prc_req, ply_req);
            rec_req = 1'b0; prc_req = 1'b0; ply_req = 1'b0;
        end
        n_vec++;
        if (order.size() != 3) begin
            n_bad++;
            $display("FAIL cont_grants got=%0d exp=3", order.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (order[i] != exp_order[i]) begin
                    n_bad++;
                    $display("FAIL cont_order idx=%0d got=%0d exp=%0d", i, order[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int seen;
        do_reset();
        prc_req = 1'b1; prc_addr = 7'd9;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1 || gnt_id !== 2'd2) begin
            n_bad++;
            $display("FAIL mid_inflight got busy=%b gnt=%0d exp 1 2", busy, gnt_id);
        end
        rst = 1'b1; prc_req = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, gnt_id, rec_ack, prc_ack, ply_ack, addr_err, mem_wren} !== 8'h00 ||
            mem_addr !== '0 || rd_data !== '0 || mem_wdata !== '0) begin
            n_bad++;
            $display("FAIL mid_reset got ctrl=%b addr=%0d rd=%h exp all zero",
                     {busy, gnt_id, rec_ack, prc_ack, ply_ack, addr_err, mem_wren}, mem_addr, rd_data);
        end
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (prc_ack) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL mid_no_ack got=%0d acks exp=0", seen);
        end
        prc_req = 1'b1; prc_addr = 7'd5;
        for (int k = 1; k <= RD_LAT + 2; k++) @(negedge clk);
        n_vec++;
        if (prc_ack !== 1'b1 || rd_data !== exp_word(7'd5)) begin
            n_bad++;
            $display("FAIL mid_recover got ack=%b rd=%h exp ack=1 rd=%h", prc_ack, rd_data, exp_word(7'd5));
        end
        prc_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        int first, exp_first, cyc;
        bit ply_done;
`ifdef ARB_RR_EN
        exp_first = 3;
`else
        exp_first = 1;
`endif
        do_reset();
        rec_req = 1'b1; rec_addr = 7'd20; rec_wdata = rand_word();
        cyc = 0;
        while (!rec_ack && cyc < 10) begin @(negedge clk); cyc++; end
        n_vec++;
        if (!rec_ack) begin
            n_bad++;
            $display("FAIL starve_first got no rec_ack exp rec_ack within 10 cycles");
        end
        ply_req = 1'b1; ply_addr = 7'd30;
        first = 0; ply_done = 1'b0;
        for (int i = 0; i < 60 && !ply_done; i++) begin
            @(negedge clk);
            if (rec_ack) begin
                if (first == 0) first = 1;
                rec_req = 1'b0;
            end
            if (ply_ack) begin
                if (first == 0) first = 3;
                ply_req = 1'b0;
                ply_done = 1'b1;
            end
        end
        n_vec++;
        if (!ply_done) begin
            n_bad++;
            $display("FAIL starve_timeout got ply unserved exp ply_ack within 60 cycles");
        end
        n_vec++;
        if (first != exp_first) begin
            n_bad++;
            $display("FAIL starve_next_grant got=%0d exp=%0d", first, exp_first);
        end
        rec_req = 1'b0; ply_req = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rec_req = 1'b0; prc_req = 1'b0; ply_req = 1'b0;
        rec_addr = '0; prc_addr = '0; ply_addr = '0; rec_wdata = '0;
        test_reset();
        test_random();
        test_write_read();
        test_latency();
        test_out_of_range();
        test_contention();
        test_reset_mid_read();
        test_starvation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aud_mem_arbiter.md
Name: aud_mem_arbiter

Overview:
- Shares one single-port audio word memory (256-bit words, 7-bit address) between three requesters: the recorder (write), the echo processor (read) and the player (read).
- Sits between the record, process and play controllers and the memory macro. It owns the memory address, data and write-enable pins.
- Serialises accesses, hides the read latency, and returns read data with a one-cycle valid/ack pulse to the requester that was granted.

Parameters:
- ADDR_W, 7, memory address width.
- DATA_W, 256, memory word width (one word is 256 one-bit audio samples).
- RD_LAT, 1, memory read latency in clocks from address to q; legal range 1..3.
- LAST_ADDR, 122, highest legal word address; anything above it is out of range.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- rec_req  in  1  recorder write request; held until rec_ack
- rec_addr  in  ADDR_W  recorder word address
- rec_wdata  in  DATA_W  recorder word to write
- rec_ack  out  1  one-cycle pulse: write done, or write rejected
- prc_req  in  1  processor read request; held until prc_ack
- prc_addr  in  ADDR_W  processor read address
- prc_ack  out  1  one-cycle pulse: rd_data valid for processor
- ply_req  in  1  player read request; held until ply_ack
- ply_addr  in  ADDR_W  player read address
- ply_ack  out  1  one-cycle pulse: rd_data valid for player
- rd_data  out  DATA_W  registered read word; valid only in an ack cycle
- addr_err  out  1  one-cycle pulse together with the ack of an out-of-range request
- busy  out  1  high in every state except IDLE
- gnt_id  out  2  current owner: 0 none, 1 rec, 2 prc, 3 ply
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory data
- mem_wren  out  1  to memory write enable
- mem_q  in  DATA_W  memory read data

Behaviour:
- Reset and clocking:
  - Single clock clk. rst is synchronous and active-high.
  - On reset, all outputs are 0, the FSM is in IDLE, the round-robin pointer points at rec, and the wait counter is 0.
  - Reset asserted mid-access aborts the access: no ack is issued and mem_wren is forced low in the next cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples the request lines and picks a winner (arbitration rule below).
  - If there is a winner: latch its id, address and (for rec) its wdata, then go to ISSUE.
  - If there is no winner: stay in IDLE, gnt_id=0.
  - If the latched address is greater than LAST_ADDR, go to RESP directly with the error flag set; memory is not touched.
- ISSUE:
  - Drive mem_addr with the latched address.
  - Write (rec): mem_wren=1 for exactly this cycle, mem_wdata=latched word, rec_ack pulses this cycle, next state IDLE.
  - Read (prc or ply): mem_wren=0, load the counter with RD_LAT-1, next state WAIT.
- WAIT:
  - mem_addr is held. The counter decrements each cycle.
  - When the counter is 0: rd_data <= mem_q, next state RESP.
- RESP:
  - Pulse the ack of the owner for one cycle; rd_data stays stable.
  - addr_err pulses if the request was out of range; rd_data is then unchanged from its previous value.
  - Next state IDLE.
- Latency, with the request sampled in IDLE at cycle 0:
  - Write ack at cycle 1.
  - Read ack at cycle RD_LAT+2 (cycle 3 for RD_LAT=1).
  - Out-of-range ack at cycle 1.
- Handshake rules:
  - A requester holds req and its address/data stable until it sees its ack.
  - It may drop req in the ack cycle or keep it high. If it keeps it high, that is a new request, arbitrated in the next IDLE.
  - Changes to address/data after the grant are ignored.
  - A req that drops before being granted is simply never served; no ack is issued.
- Arbitration (default): fixed priority rec > prc > ply. Used only when ARB_RR_EN is not defined.
- Mutual exclusion and timing:
  - Exactly one access is in flight at a time.
  - IDLE sits between any two grants, so the minimum spacing is 2 cycles for back-to-back writes and RD_LAT+3 cycles for back-to-back reads.
  - gnt_id shows the owner from ISSUE through RESP. For an out-of-range request it shows the owner in RESP.
- Outside ISSUE and WAIT, mem_addr holds its last value and mem_wren=0.
- Simultaneous events: a request arriving in the same cycle that another requester is acked is arbitrated in the following IDLE.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration.
  - Search order starts at the requester after the last granted one (rec -> prc -> ply -> rec).
  - The pointer advances only on a grant, including out-of-range grants.
  - The pointer resets to rec, so after reset the search starts at prc.
- Undefined: fixed priority rec > prc > ply; the pointer logic is absent.

Test Plan:
- Write and read back: rec write addr=5, data=0xA5..A5 -> mem_wren high one cycle at cycle 1 with mem_addr=5 and rec_ack at cycle 1. Then prc read addr=5 (RD_LAT=1) -> prc_ack at cycle 3 with rd_data=0xA5..A5.
- Contention: rec, prc and ply all request at cycle 0, each dropping req on its own ack.
  - Fixed priority: grant order rec, prc, ply.
  - ARB_RR_EN: grant order prc, ply, rec.
  - No overlap in any case; gnt_id sequence matches the grant order.
- Out of range: ply read addr=123 -> ply_ack and addr_err at cycle 1, mem_addr/mem_wren untouched, rd_data unchanged.
- Latency sweep: RD_LAT=3, prc read addr=0 -> prc_ack at cycle 5; mem_addr held at 0 for cycles 1-4.
- Reset mid-read: assert rst during WAIT -> no prc_ack, all outputs 0 the next cycle. A request after reset is served normally.
- Starvation check (ARB_RR_EN): rec holds req continuously while ply requests once -> ply is served within 2 grants.
